rob_completion_commit: RTL and testbench

- 16-entry reorder buffer and the consumer end of the completion interface driven by the EX/MEM stage register. The EX/MEM register sends completion index, value and complete strobe.
- Allocates entries in program order at issue, accepts out-of-order completions from EX/MEM (ALU results) and from MEM (load results), and retires in order to the register file.
- Raises a precise exception and flushes itself when the head entry carries a nonzero exception vector.

---
 rtl/rob_completion_commit.sv | 159 +++++++++++++++
 tb/tb_rob_completion_commit.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_completion_commit.sv
// 16-entry reorder buffer: in-order allocation at issue, out-of-order completion
// from the EX/MEM register and from the MEM load path, in-order retirement to the
// register file, and a precise exception with a full flush when the head faults.
module rob_completion_commit #(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = 4,
    parameter int XLEN    = 32
) (
    input  logic               clk,
    input  logic               reset,

    input  logic               in_alloc_valid,
    input  logic [4:0]         in_alloc_rd,
    input  logic               in_alloc_write_enable,
    input  logic [XLEN-1:0]    in_alloc_pc,
    output logic               out_alloc_ready,
    output logic [IDX_W-1:0]   out_alloc_idx,

    input  logic               in_complete,
    input  logic [IDX_W-1:0]   in_complete_idx,
    input  logic [XLEN-1:0]    in_complete_value,
    input  logic [2:0]         in_exception_vector,

    input  logic               in_mem_complete,
    input  logic [IDX_W-1:0]   in_mem_complete_idx,
    input  logic [XLEN-1:0]    in_mem_complete_value,

    output logic               out_commit_valid,
    output logic [IDX_W-1:0]   out_commit_idx,
    output logic [4:0]         out_commit_rd,
    output logic [XLEN-1:0]    out_commit_value,
    output logic               out_commit_write_enable,

    output logic               out_exception,
    output logic [XLEN-1:0]    out_exception_pc,
    output logic [2:0]         out_exception_vector,

    output logic [IDX_W:0]     out_count
);

    localparam logic [IDX_W:0]   FULL_CNT = (IDX_W+1)'(ENTRIES);
    localparam logic [IDX_W:0]   CNT_ONE  = (IDX_W+1)'(1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    // Control state (reset) and payload state (not reset)
    logic [ENTRIES-1:0] ent_valid;
    logic [ENTRIES-1:0] ent_complete;
    logic [2:0]         ent_exc   [ENTRIES];
    logic [ENTRIES-1:0] ent_we;
    logic [4:0]         ent_rd    [ENTRIES];
    logic [XLEN-1:0]    ent_pc    [ENTRIES];
    logic [XLEN-1:0]    ent_value [ENTRIES];

    logic [IDX_W-1:0]   head;
    logic [IDX_W-1:0]   tail;
    logic [IDX_W:0]     count;

    logic head_done;
    logic exc_fire;
    logic commit_fire;
    logic alloc_fire;
    logic cpl_ex;
    logic cpl_mem;

    assign out_alloc_ready = (count != FULL_CNT);
    assign out_alloc_idx   = tail;
    assign out_count       = count;

    // Head retirement decision and gating of same-cycle allocate/complete on a flush
    always_comb begin
        head_done   = ent_valid[head] && ent_complete[head];
        exc_fire    = head_done && (ent_exc[head] != 3'd0);
        commit_fire = head_done && (ent_exc[head] == 3'd0);
        alloc_fire  = in_alloc_valid && out_alloc_ready && !exc_fire;
        cpl_ex      = in_complete && ent_valid[in_complete_idx] && !exc_fire;
        cpl_mem     = in_mem_complete && ent_valid[in_mem_complete_idx] && !exc_fire;
    end

    // Entry payload capture; the MEM write comes last so it wins on an index clash
    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            ent_rd[tail] <= in_alloc_rd;
            ent_we[tail] <= in_alloc_write_enable;
            ent_pc[tail] <= in_alloc_pc;
        end
        if (cpl_ex) begin
            ent_value[in_complete_idx] <= in_complete_value;
        end
        if (cpl_mem) begin
            ent_value[in_mem_complete_idx] <= in_mem_complete_value;
        end
    end

    // Pointers, entry status, flush and registered commit/exception outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ent_valid               <= '0;
            ent_complete            <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                ent_exc[i] <= 3'd0;
            end
            head                    <= '0;
            tail                    <= '0;
            count                   <= '0;
            out_commit_valid        <= 1'b0;
            out_commit_idx          <= '0;
            out_commit_rd           <= 5'd0;
            out_commit_value        <= '0;
            out_commit_write_enable <= 1'b0;
            out_exception           <= 1'b0;
            out_exception_pc        <= '0;
            out_exception_vector    <= 3'd0;
        end else begin
            out_commit_valid        <= commit_fire;
            out_commit_write_enable <= commit_fire && ent_we[head];
            out_exception           <= exc_fire;
            if (commit_fire) begin
                out_commit_idx   <= head;
                out_commit_rd    <= ent_rd[head];
                out_commit_value <= ent_value[head];
            end
            if (exc_fire) begin
                out_exception_pc     <= ent_pc[head];
                out_exception_vector <= ent_exc[head];
                ent_valid            <= '0;
                ent_complete         <= '0;
                head                 <= '0;
                tail                 <= '0;
                count                <= '0;
            end else begin
                if (commit_fire) begin
                    ent_valid[head]    <= 1'b0;
                    ent_complete[head] <= 1'b0;
                    head               <= head + IDX_ONE;
                end
                if (cpl_ex) begin
                    ent_complete[in_complete_idx] <= 1'b1;
                    ent_exc[in_complete_idx]      <= in_exception_vector;
                end
                if (cpl_mem) begin
                    ent_complete[in_mem_complete_idx] <= 1'b1;
                    ent_exc[in_mem_complete_idx]      <= 3'd0;
                end
                if (alloc_fire) begin
                    ent_valid[tail]    <= 1'b1;
                    ent_complete[tail] <= 1'b0;
                    ent_exc[tail]      <= 3'd0;
                    tail               <= tail + IDX_ONE;
                end
                case ({alloc_fire, commit_fire})
                    2'b10:   count <= count + CNT_ONE;
                    2'b01:   count <= count - CNT_ONE;
                    default: count <= count;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rob_completion_commit.sv
// Scoreboard bench for rob_completion_commit: directed stimulus pushes expected
// commits/exceptions into queues, a negedge monitor pops and compares them.
module tb_rob_completion_commit;

    logic        clk;
    logic        reset;
    logic        in_alloc_valid;
    logic [4:0]  in_alloc_rd;
    logic        in_alloc_write_enable;
    logic [31:0] in_alloc_pc;
    logic        out_alloc_ready;
    logic [3:0]  out_alloc_idx;
    logic        in_complete;
    logic [3:0]  in_complete_idx;
    logic [31:0] in_complete_value;
    logic [2:0]  in_exception_vector;
    logic        in_mem_complete;
    logic [3:0]  in_mem_complete_idx;
    logic [31:0] in_mem_complete_value;
    logic        out_commit_valid;
    logic [3:0]  out_commit_idx;
    logic [4:0]  out_commit_rd;
    logic [31:0] out_commit_value;
    logic        out_commit_write_enable;
    logic        out_exception;
    logic [31:0] out_exception_pc;
    logic [2:0]  out_exception_vector;
    logic [4:0]  out_count;

    rob_completion_commit #(.ENTRIES(16), .IDX_W(4), .XLEN(32)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .in_alloc_valid          (in_alloc_valid),
        .in_alloc_rd             (in_alloc_rd),
        .in_alloc_write_enable   (in_alloc_write_enable),
        .in_alloc_pc             (in_alloc_pc),
        .out_alloc_ready         (out_alloc_ready),
        .out_alloc_idx           (out_alloc_idx),
        .in_complete             (in_complete),
        .in_complete_idx         (in_complete_idx),
        .in_complete_value       (in_complete_value),
        .in_exception_vector     (in_exception_vector),
        .in_mem_complete         (in_mem_complete),
        .in_mem_complete_idx     (in_mem_complete_idx),
        .in_mem_complete_value   (in_mem_complete_value),
        .out_commit_valid        (out_commit_valid),
        .out_commit_idx          (out_commit_idx),
        .out_commit_rd           (out_commit_rd),
        .out_commit_value        (out_commit_value),
        .out_commit_write_enable (out_commit_write_enable),
        .out_exception           (out_exception),
        .out_exception_pc        (out_exception_pc),
        .out_exception_vector    (out_exception_vector),
        .out_count               (out_count)
    );

    typedef struct {
        logic [3:0]  idx;
        logic [4:0]  rd;
        logic [31:0] val;
        logic        we;
    } commit_t;

    typedef struct {
        logic [31:0] pc;
        logic [2:0]  vec;
    } exc_t;

    commit_t exp_q[$];
    exc_t    exc_q[$];
    int      total = 0;
    int      bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        in_alloc_valid        = 1'b0;
        in_alloc_rd           = 5'd0;
        in_alloc_write_enable = 1'b0;
        in_alloc_pc           = 32'd0;
        in_complete           = 1'b0;
        in_complete_idx       = 4'd0;
        in_complete_value     = 32'd0;
        in_exception_vector   = 3'd0;
        in_mem_complete       = 1'b0;
        in_mem_complete_idx   = 4'd0;
        in_mem_complete_value = 32'd0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
    endtask

    task automatic do_alloc(input logic [4:0] rd, input logic we, input logic [31:0] pc, input int exp_idx);
        chk("alloc_idx", 64'(out_alloc_idx), 64'(exp_idx));
        in_alloc_valid        = 1'b1;
        in_alloc_rd           = rd;
        in_alloc_write_enable = we;
        in_alloc_pc           = pc;
        step();
        clear_inputs();
    endtask

    task automatic do_complete(input logic [3:0] idx, input logic [31:0] val, input logic [2:0] exc);
        in_complete         = 1'b1;
        in_complete_idx     = idx;
        in_complete_value   = val;
        in_exception_vector = exc;
        step();
        clear_inputs();
    endtask

    task automatic do_mem_complete(input logic [3:0] idx, input logic [31:0] val);
        in_mem_complete       = 1'b1;
        in_mem_complete_idx   = idx;
        in_mem_complete_value = val;
        step();
        clear_inputs();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || exc_q.size() != 0) && n < 64) begin
            step();
            n++;
        end
        chk("drain_pending", 64'(exp_q.size() + exc_q.size()), 64'd0);
        repeat (3) step();
    endtask

    // Monitor: every presented commit or exception must match the head of its queue
    always @(negedge clk) begin
        commit_t e;
        exc_t    x;
        if (reset) begin
            if (out_commit_valid) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL commit_unexpected: got idx=%0d value=%0h required no commit",
                             out_commit_idx, out_commit_value);
                end else begin
                    e = exp_q.pop_front();
                    if (out_commit_idx !== e.idx || out_commit_rd !== e.rd ||
                        out_commit_value !== e.val || out_commit_write_enable !== e.we) begin
                        bad++;
                        $display("FAIL commit: got idx=%0d rd=%0d value=%0h we=%0b required idx=%0d rd=%0d value=%0h we=%0b",
                                 out_commit_idx, out_commit_rd, out_commit_value, out_commit_write_enable,
                                 e.idx, e.rd, e.val, e.we);
                    end
                end
            end
            if (out_exception) begin
                total++;
                if (exc_q.size() == 0) begin
                    bad++;
                    $display("FAIL exception_unexpected: got pc=%0h vec=%0d required none",
                             out_exception_pc, out_exception_vector);
                end else begin
                    x = exc_q.pop_front();
                    if (out_exception_pc !== x.pc || out_exception_vector !== x.vec) begin
                        bad++;
                        $display("FAIL exception: got pc=%0h vec=%0d required pc=%0h vec=%0d",
                                 out_exception_pc, out_exception_vector, x.pc, x.vec);
                    end
                end
            end
        end
    end

    initial begin
        clear_inputs();
        reset = 1'b0;
        #22;
        reset = 1'b1;
        step();

        // Reset state
        chk("rst_count", 64'(out_count), 64'd0);
        chk("rst_ready", 64'(out_alloc_ready), 64'd1);
        chk("rst_alloc_idx", 64'(out_alloc_idx), 64'd0);
        chk("rst_commit_valid", 64'(out_commit_valid), 64'd0);
        chk("rst_exception", 64'(out_exception), 64'd0);

        // 1: out-of-order completion, in-order retirement
        do_alloc(5'd1, 1'b1, 32'h0, 0);
        do_alloc(5'd2, 1'b1, 32'h4, 1);
        do_alloc(5'd3, 1'b1, 32'h8, 2);
        chk("t1_count", 64'(out_count), 64'd3);
        exp_q.push_back('{4'd0, 5'd1, 32'h00, 1'b1});
        exp_q.push_back('{4'd1, 5'd2, 32'h11, 1'b1});
        exp_q.push_back('{4'd2, 5'd3, 32'h22, 1'b1});
        do_complete(4'd2, 32'h22, 3'd0);
        chk("t1_no_early_commit", 64'(out_commit_valid), 64'd0);
        do_complete(4'd0, 32'h00, 3'd0);
        chk("t1_latency_wait", 64'(out_commit_valid), 64'd0);
        do_complete(4'd1, 32'h11, 3'd0);
        chk("t1_latency_valid", 64'(out_commit_valid), 64'd1);
        chk("t1_latency_idx", 64'(out_commit_idx), 64'd0);
        drain();
        chk("t1_count_end", 64'(out_count), 64'd0);

        // 2: fill to 16, overflow request ignored, retire frees one slot
        do_reset();
        for (int i = 0; i < 16; i++) begin
            do_alloc(5'(i + 1), 1'b1, 32'h1000 + 32'(4 * i), i);
        end
        chk("t2_full_ready", 64'(out_alloc_ready), 64'd0);
        chk("t2_full_count", 64'(out_count), 64'd16);
        in_alloc_valid = 1'b1;
        in_alloc_rd    = 5'd31;
        in_alloc_pc    = 32'hFFFF;
        step();
        clear_inputs();
        chk("t2_overflow_count", 64'(out_count), 64'd16);
        chk("t2_overflow_idx", 64'(out_alloc_idx), 64'd0);
        exp_q.push_back('{4'd0, 5'd1, 32'hA0, 1'b1});
        do_complete(4'd0, 32'hA0, 3'd0);
        chk("t2_retire_cycle_ready", 64'(out_alloc_ready), 64'd0);
        chk("t2_retire_cycle_count", 64'(out_count), 64'd16);
        step();
        chk("t2_after_ready", 64'(out_alloc_ready), 64'd1);
        chk("t2_after_count", 64'(out_count), 64'd15);

        // 3+4: retire the rest (idx 5 dual-port, idx 7 via MEM), then wrap
        for (int i = 1; i < 16; i++) begin
            if (i == 5) begin
                exp_q.push_back('{4'd5, 5'd6, 32'hBBBB, 1'b1});
                in_complete           = 1'b1;
                in_complete_idx       = 4'd5;
                in_complete_value     = 32'hAAAA;
                in_mem_complete       = 1'b1;
                in_mem_complete_idx   = 4'd5;
                in_mem_complete_value = 32'hBBBB;
                step();
                clear_inputs();
            end else if (i == 7) begin
                exp_q.push_back('{4'd7, 5'd8, 32'h777, 1'b1});
                do_mem_complete(4'd7, 32'h777);
            end else begin
                exp_q.push_back('{4'(i), 5'(i + 1), 32'hA0 + 32'(i), 1'b1});
                do_complete(4'(i), 32'hA0 + 32'(i), 3'd0);
            end
        end
        drain();
        chk("t3_count_empty", 64'(out_count), 64'd0);
        exp_q.push_back('{4'd0, 5'd9, 32'h5555, 1'b0});
        do_alloc(5'd9, 1'b0, 32'h3000, 0);
        do_complete(4'd0, 32'h5555, 3'd0);
        drain();

        // 5: precise exception, flush, same-cycle allocation dropped
        do_reset();
        do_alloc(5'd4, 1'b1, 32'h100, 0);
        do_alloc(5'd5, 1'b1, 32'h104, 1);
        do_alloc(5'd6, 1'b1, 32'h108, 2);
        exp_q.push_back('{4'd0, 5'd4, 32'h1, 1'b1});
        exc_q.push_back('{32'h104, 3'd3});
        do_complete(4'd1, 32'hDEAD, 3'd3);
        do_complete(4'd0, 32'h1, 3'd0);
        do_complete(4'd2, 32'h2, 3'd0);
        in_alloc_valid        = 1'b1;
        in_alloc_rd           = 5'd7;
        in_alloc_write_enable = 1'b1;
        in_alloc_pc           = 32'h200;
        step();
        clear_inputs();
        chk("t5_exception", 64'(out_exception), 64'd1);
        chk("t5_exc_pc", 64'(out_exception_pc), 64'h104);
        chk("t5_exc_vec", 64'(out_exception_vector), 64'd3);
        chk("t5_no_commit", 64'(out_commit_valid), 64'd0);
        chk("t5_count_flushed", 64'(out_count), 64'd0);
        chk("t5_tail_flushed", 64'(out_alloc_idx), 64'd0);
        step();
        chk("t5_exc_pulse_end", 64'(out_exception), 64'd0);
        drain();

        // 6: asynchronous reset while entries are pending
        do_alloc(5'd1, 1'b1, 32'h400, 0);
        do_alloc(5'd2, 1'b1, 32'h404, 1);
        do_alloc(5'd3, 1'b1, 32'h408, 2);
        do_alloc(5'd4, 1'b1, 32'h40C, 3);
        do_complete(4'd0, 32'h77, 3'd0);
        step();
        chk("t6_pre_commit_valid", 64'(out_commit_valid), 64'd1);
        chk("t6_pre_count", 64'(out_count), 64'd3);
        #1;
        reset = 1'b0;
        #1;
        chk("t6_commit_valid_cleared", 64'(out_commit_valid), 64'd0);
        chk("t6_commit_value_cleared", 64'(out_commit_value), 64'd0);
        chk("t6_count_cleared", 64'(out_count), 64'd0);
        chk("t6_alloc_idx_cleared", 64'(out_alloc_idx), 64'd0);
        step();
        reset = 1'b1;
        step();
        do_alloc(5'd10, 1'b1, 32'h500, 0);
        chk("t6_count_after", 64'(out_count), 64'd1);
        repeat (3) step();
        chk("t6_no_stray", 64'(exp_q.size() + exc_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
